// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
//   CPU-side initiator for the shared memory bus. Two internal clients
//   (instruction fetch, read-only; load/store unit, read/write with byte
//   enables) are arbitrated round-robin. One transaction at a time is
//   carried to the bus, and the winner gets a one-cycle done pulse.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     When it is defined, a WAIT-cycle limit (TIMEOUT_CYCLES) aborts a bus
//     transaction that never sees ready. The abort sets the sticky o_error
//     output and returns data 0 to the winner.
//
// Ports
//   i_clock, i_reset            clock (rising edge), synchronous active-high reset
//   i_fetch_req/_address        fetch request (held until done), word address
//   o_fetch_data/_done          fetch read data, one-cycle completion pulse
//   i_data_req/_write/_address  load/store request, 1 = store, address
//   i_data_wdata/_byte_en       store data and byte enables
//   o_data_rdata/_done          load data, one-cycle completion pulse
//   o_mem_address/_wdata/_byte_en  bus request fields (byte_en all ones on reads)
//   o_mem_read/_write           bus strobes, never both high
//   i_mem_rdata/_ready          responder read data and completion
//   o_error                     sticky timeout flag (MEM_TIMEOUT_EN only)
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | sample both requests, pick a winner, capture its request
// ISSUE   | first strobe cycle; ready is ignored here
// WAIT    | strobe held until ready (or the timeout, when enabled)
// RESPOND | winner's done pulses for one cycle

module mem_bus_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]   i_fetch_address,
  output logic [DATA_WIDTH-1:0]   o_fetch_data,
  output logic                    o_fetch_done,
  input  logic                    i_data_req,
  input  logic                    i_data_write,
  input  logic [ADDR_WIDTH-1:0]   i_data_address,
  input  logic [DATA_WIDTH-1:0]   i_data_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_data_byte_en,
  output logic [DATA_WIDTH-1:0]   o_data_rdata,
  output logic                    o_data_done,
  output logic [ADDR_WIDTH-1:0]   o_mem_address,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_byte_en,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_ready
`ifdef MEM_TIMEOUT_EN
  , output logic                  o_error
`endif
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;           // 1 = data client favoured on a tie
  logic                  win_data_q, win_data_d; // 1 = current winner is load/store
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  grant_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_data_d   = win_data_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    grant_data   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    error_d      = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_fetch_req || i_data_req) begin
          grant_data = i_data_req && (!i_fetch_req || ptr_q);
          // On a tie the pointer moves to the loser, so it wins the next tie.
          if (i_fetch_req && i_data_req) begin
            ptr_d = ~ptr_q;
          end
          win_data_d = grant_data;
          if (grant_data) begin
            addr_d  = i_data_address;
            wr_d    = i_data_write;
            wdata_d = i_data_write ? i_data_wdata : '0;
            be_d    = i_data_write ? i_data_byte_en : '1;
          end else begin
            addr_d  = i_fetch_address;
            wr_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef MEM_TIMEOUT_EN
        // The counter reaches zero on the last permitted WAIT cycle.
        cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i_mem_ready) begin
          if (!wr_q) begin
            if (win_data_q) data_rdata_d = i_mem_rdata;
            else            fetch_data_d = i_mem_rdata;
          end
          state_d = S_RESPOND;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == '0) begin
          error_d = 1'b1;
          if (win_data_q) data_rdata_d = '0;
          else            fetch_data_d = '0;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end

      S_RESPOND: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= 1'b1;
      win_data_q   <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_data_q   <= win_data_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  logic bus_active;
  assign bus_active    = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign o_mem_address = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_mem_byte_en = be_q;
  assign o_mem_read    = bus_active && !wr_q;
  assign o_mem_write   = bus_active && wr_q;

  assign o_fetch_data  = fetch_data_q;
  assign o_data_rdata  = data_rdata_q;
  assign o_fetch_done  = (state_q == S_RESPOND) && !win_data_q;
  assign o_data_done   = (state_q == S_RESPOND) && win_data_q;

`ifdef MEM_TIMEOUT_EN
  assign o_error       = error_q;
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
module tb_mem_bus_initiator;

  logic        clk;
  logic        i_reset;
  logic        i_fetch_req;
  logic [31:0] i_fetch_address;
  logic [31:0] o_fetch_data;
  logic        o_fetch_done;
  logic        i_data_req;
  logic        i_data_write;
  logic [31:0] i_data_address;
  logic [31:0] i_data_wdata;
  logic [3:0]  i_data_byte_en;
  logic [31:0] o_data_rdata;
  logic        o_data_done;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_byte_en;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;
`ifdef MEM_TIMEOUT_EN
  logic        o_error;
`endif

  mem_bus_initiator #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_fetch_req     (i_fetch_req),
    .i_fetch_address (i_fetch_address),
    .o_fetch_data    (o_fetch_data),
    .o_fetch_done    (o_fetch_done),
    .i_data_req      (i_data_req),
    .i_data_write    (i_data_write),
    .i_data_address  (i_data_address),
    .i_data_wdata    (i_data_wdata),
    .i_data_byte_en  (i_data_byte_en),
    .o_data_rdata    (o_data_rdata),
    .o_data_done     (o_data_done),
    .o_mem_address   (o_mem_address),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_byte_en   (o_mem_byte_en),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (o_mem_write),
    .i_mem_rdata     (i_mem_rdata),
    .i_mem_ready     (i_mem_ready)
`ifdef MEM_TIMEOUT_EN
    , .o_error       (o_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: word-addressed RAM. Ready rises in strobe cycle rdy_at
  // (1 = first strobe cycle) and stays high until the strobe drops.
  logic [31:0] mem [int];
  int          rdy_at      = 1;
  bit          ready_force = 1'b0;
  int          stb_cnt     = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    if (o_mem_read || o_mem_write) begin
      stb_cnt = stb_cnt + 1;
      if (ready_force || stb_cnt >= rdy_at) begin
        i_mem_ready = 1'b1;
        if (o_mem_read) begin
          i_mem_rdata = mem_rd(o_mem_address);
        end else begin
          w = mem_rd(o_mem_address);
          for (int b = 0; b < 4; b++)
            if (o_mem_byte_en[b]) w[b*8 +: 8] = o_mem_wdata[b*8 +: 8];
          mem[int'(o_mem_address >> 2)] = w;
          i_mem_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      stb_cnt     = 0;
      i_mem_ready = ready_force;
      i_mem_rdata = 32'hBAD0_BAD0;
    end
  end

  // Running totals of bus activity; the main sequence compares deltas.
  int          rd_total = 0, wr_total = 0, both_total = 0, fd_total = 0, dd_total = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  always @(negedge clk) begin
    if (o_mem_read) rd_total++;
    if (o_mem_write) wr_total++;
    if (o_mem_read && o_mem_write) both_total++;
    if (o_fetch_done) fd_total++;
    if (o_data_done) dd_total++;
    if (o_mem_read || o_mem_write) begin
      s_addr  = o_mem_address;
      s_wdata = o_mem_wdata;
      s_be    = o_mem_byte_en;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advances at least one cycle, then until a done pulse or the limit.
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(o_fetch_done || o_data_done) && lat < limit);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes_done"}, {60'h0, o_mem_read, o_mem_write, o_fetch_done, o_data_done}, 64'h0);
    check({tag, "_addr_wdata"}, {o_mem_address, o_mem_wdata}, 64'h0);
    check({tag, "_byte_en"}, {60'h0, o_mem_byte_en}, 64'h0);
    check({tag, "_rdata"}, {o_fetch_data, o_data_rdata}, 64'h0);
`ifdef MEM_TIMEOUT_EN
    check({tag, "_error"}, {63'h0, o_error}, 64'h0);
`endif
  endtask

  initial begin
    int lat, rd0, wr0, fd0, dd0, both0;
    bit got [4];

    mem[32'h40 >> 2]  = 32'h1234_5678;
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    mem[32'h204 >> 2] = 32'hAABB_CCDD;
    mem[32'h300 >> 2] = 32'hF0F0_0300;
    mem[32'h304 >> 2] = 32'hD0D0_0304;

    i_reset = 1'b1;
    i_fetch_req = 0; i_fetch_address = 0;
    i_data_req = 0; i_data_write = 0; i_data_address = 0;
    i_data_wdata = 0; i_data_byte_en = 0;
    i_mem_ready = 0; i_mem_rdata = 0;
    ready_force = 1'b1;
    idle(3);
    check_all_zero("reset");
    i_reset = 1'b0;

    // Ready held high with no request: nothing may happen on the bus.
    rd0 = rd_total; wr0 = wr_total; fd0 = fd_total; dd0 = dd_total;
    idle(5);
    check("ready_idle_no_activity", 64'(rd_total - rd0 + wr_total - wr0 + fd_total - fd0 + dd_total - dd0), 64'd0);

    // First transaction under permanent ready: minimum latency of 3.
    i_data_req = 1; i_data_write = 0; i_data_address = 32'h40; i_data_byte_en = 4'h0;
    wait_done(20, lat);
    check("min_latency", 64'(lat), 64'd3);
    check("min_lat_rdata", 64'(o_data_rdata), 64'h1234_5678);
    i_data_req = 0;
    ready_force = 1'b0;
    idle(2);

    // Single fetch; client address changes while pending must be ignored.
    rd0 = rd_total; wr0 = wr_total; fd0 = fd_total; dd0 = dd_total;
    rdy_at = 2;
    i_fetch_req = 1; i_fetch_address = 32'h100;
    @(negedge clk);
    i_fetch_address = 32'h0000_0FF0;
    wait_done(20, lat);
    check("fetch_latency", 64'(lat + 1), 64'd3);
    check("fetch_data", 64'(o_fetch_data), 64'hDEAD_BEEF);
    check("fetch_done_pulse", {62'h0, o_fetch_done, o_data_done}, 64'h2);
    i_fetch_req = 0;
    idle(3);
    check("fetch_read_cycles", 64'(rd_total - rd0), 64'd2);
    check("fetch_no_write", 64'(wr_total - wr0), 64'd0);
    check("fetch_done_count", 64'(fd_total - fd0), 64'd1);
    check("fetch_bus_addr_be", {28'h0, s_be, s_addr}, {28'h0, 4'hF, 32'h100});

    // Partial store followed by a load of the same word.
    rd0 = rd_total; wr0 = wr_total; dd0 = dd_total;
    rdy_at = 3;
    i_data_req = 1; i_data_write = 1; i_data_address = 32'h204;
    i_data_wdata = 32'h1122_3344; i_data_byte_en = 4'b0011;
    wait_done(20, lat);
    check("store_latency", 64'(lat), 64'd4);
    check("store_done", {62'h0, o_fetch_done, o_data_done}, 64'h1);
    check("store_keeps_rdata", 64'(o_data_rdata), 64'h1234_5678);
    i_data_req = 0;
    idle(2);
    check("store_write_cycles", {32'(wr_total - wr0), 32'(rd_total - rd0)}, {32'd3, 32'd0});
    check("store_bus_addr_data", {s_addr, s_wdata}, {32'h204, 32'h1122_3344});
    check("store_bus_be", 64'(s_be), 64'h3);

    rdy_at = 1;
    i_data_req = 1; i_data_write = 0; i_data_address = 32'h204;
    wait_done(20, lat);
    check("load_merge_rdata", 64'(o_data_rdata), 64'hAABB_3344);
    i_data_req = 0;
    idle(2);
    check("load_bus_be_ones", 64'(s_be), 64'hF);
    check("fetch_data_held", 64'(o_fetch_data), 64'hDEAD_BEEF);
    check("data_done_count", 64'(dd_total - dd0), 64'd2);

    // Both clients held high for four grants: data, fetch, data, fetch.
    fd0 = fd_total; dd0 = dd_total; both0 = both_total;
    i_fetch_req = 1; i_fetch_address = 32'h300;
    i_data_req = 1; i_data_write = 0; i_data_address = 32'h304;
    for (int k = 0; k < 4; k++) begin
      wait_done(20, lat);
      check("rr_done_seen", 64'(lat < 20), 64'd1);
      got[k] = o_data_done;
    end
    i_fetch_req = 0; i_data_req = 0;
    idle(3);
    check("rr_order", {60'h0, got[0], got[1], got[2], got[3]}, 64'b1010);
    check("rr_done_counts", {32'(fd_total - fd0), 32'(dd_total - dd0)}, {32'd2, 32'd2});
    check("rr_data", {o_fetch_data, o_data_rdata}, {32'hF0F0_0300, 32'hD0D0_0304});
    check("never_both_strobes", 64'(both_total - both0), 64'd0);

`ifdef MEM_TIMEOUT_EN
    // Responder never readies: 8 WAIT cycles after ISSUE, then abort.
    rd0 = rd_total;
    rdy_at = 1000;
    i_data_req = 1; i_data_write = 0; i_data_address = 32'h40;
    wait_done(40, lat);
    check("timeout_latency", 64'(lat), 64'd10);
    check("timeout_data_done", {62'h0, o_fetch_done, o_data_done}, 64'h1);
    check("timeout_rdata_zero", 64'(o_data_rdata), 64'h0);
    check("timeout_error", 64'(o_error), 64'h1);
    i_data_req = 0;
    idle(3);
    check("timeout_strobe_cycles", 64'(rd_total - rd0), 64'd9);
    check("timeout_error_sticky", 64'(o_error), 64'h1);
`endif

    // Reset while waiting on the bus drops the transaction silently.
    fd0 = fd_total; dd0 = dd_total;
    rdy_at = 1000;
    i_fetch_req = 1; i_fetch_address = 32'h100;
    idle(3);
    check("wait_strobe_high", 64'(o_mem_read), 64'h1);
    i_reset = 1'b1; i_fetch_req = 0;
    @(negedge clk);
    check_all_zero("mid_reset");
    i_reset = 1'b0;
    idle(3);
    check("mid_reset_no_done", {32'(fd_total - fd0), 32'(dd_total - dd0)}, 64'h0);

    rdy_at = 2;
    i_fetch_req = 1; i_fetch_address = 32'h100;
    wait_done(20, lat);
    check("post_reset_latency", 64'(lat), 64'd3);
    check("post_reset_fetch", {31'h0, o_fetch_done, o_fetch_data}, {31'h0, 1'b1, 32'hDEAD_BEEF});
    i_fetch_req = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- CPU-side initiator for the shared memory bus; the RAM model is the responder on the other end.
- Accepts word requests from two internal clients: instruction fetch (read-only) and load/store unit (read/write with byte enables).
- Arbitrates between the clients and drives one outstanding transaction at a time onto the bus.
- Returns read data and a single-cycle done pulse to the winning client.

Parameters:
- ADDR_WIDTH, 32, byte address width on client and bus side.
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, wait-cycle limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_fetch_req  in  1  fetch request; held high until o_fetch_done.
- i_fetch_address  in  ADDR_WIDTH  fetch address; word-aligned.
- o_fetch_data  out  DATA_WIDTH  fetch read data; valid in the o_fetch_done cycle.
- o_fetch_done  out  1  one-cycle completion pulse for fetch.
- i_data_req  in  1  load/store request; held high until o_data_done.
- i_data_write  in  1  1 = store, 0 = load.
- i_data_address  in  ADDR_WIDTH  load/store address.
- i_data_wdata  in  DATA_WIDTH  store data.
- i_data_byte_en  in  DATA_WIDTH/8  store byte enables.
- o_data_rdata  out  DATA_WIDTH  load data; valid in the o_data_done cycle.
- o_data_done  out  1  one-cycle completion pulse for load/store.
- o_mem_address  out  ADDR_WIDTH  bus address.
- o_mem_wdata  out  DATA_WIDTH  bus write data.
- o_mem_byte_en  out  DATA_WIDTH/8  bus byte enables; all ones for reads.
- o_mem_read  out  1  bus read strobe.
- o_mem_write  out  1  bus write strobe.
- i_mem_rdata  in  DATA_WIDTH  bus read data.
- i_mem_ready  in  1  responder completion.
- o_error  out  1  sticky timeout flag; exists only with MEM_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer favours data. Reset mid-transaction drops the transaction with no done pulse; the responder is expected to be reset in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Samples i_fetch_req and i_data_req.
  - If exactly one is high, that client wins.
  - If both are high, the pointer chooses the winner, and the pointer then toggles to the loser.
  - Winner's address, write flag, wdata and byte_en are captured into registers; go to ISSUE.
- ISSUE:
  - Registered request drives o_mem_address, o_mem_wdata and o_mem_byte_en.
  - o_mem_read or o_mem_write asserts, never both. Go to WAIT.
- WAIT:
  - Strobe, address and data stay stable until i_mem_ready is sampled high.
  - On ready: deassert the strobe; for reads, capture i_mem_rdata into the winner's data register; go to RESPOND.
  - i_mem_ready sampled in ISSUE or IDLE is ignored.
- RESPOND:
  - Pulse the winner's done for exactly one cycle, then return to IDLE.
  - o_fetch_data / o_data_rdata hold their value until the next read completes.
- Latency: request sampled in cycle N → strobe high in N+1. If ready arrives in cycle M, done is high in M+1. Minimum is 3 cycles with ready high in the first strobe cycle.
- Client changes to address or data while its request is pending are ignored; the captured copy is used.
- A client must not deassert its request before done. If it does, the transaction still completes and done still pulses.
- Request still high in the cycle after done is treated as a new request.
- Back-to-back: with both requests continuously high, grants alternate data, fetch, data, ...
- Writes return no data; o_data_rdata is unchanged after a store.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES without ready: drop the strobe, set o_error (sticky until reset), pulse the winner's done with data 0, return to IDLE.
- Undefined: no counter and no o_error port; WAIT lasts indefinitely.

Test Plan:
- Single fetch: fetch_req, address 0x100, RAM word 0xDEADBEEF, ready after 2 cycles → o_mem_read high 2 cycles; o_fetch_done one pulse with 0xDEADBEEF; o_mem_write never high.
- Store with byte_en 4'b0011, address 0x204, wdata 0x11223344 → o_mem_write with matching address, data and enables; o_data_done pulse; a subsequent load of 0x204 returns the low half 0x3344 merged with prior contents.
- Simultaneous requests held for 4 transactions → grant order data, fetch, data, fetch; each done exactly once per grant.
- Ready held high from reset → no bus strobe and no done until a request arrives; first transaction completes in 3 cycles.
- Reset asserted during WAIT → all outputs 0 next cycle, no done pulse; a fresh fetch then completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, responder never readies → strobe drops after 8 WAIT cycles; o_error=1; o_data_done pulses with rdata 0.
